// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the IF/ID and ID/EX registers of the 5-stage MIPS core.
// Define HAZARD_FWD_EN to enable EX-stage forwarding; otherwise RAW hazards are resolved by stalling.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             startin,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_rd,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             mem_wait,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, FREEZE, HALT} state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic              mem_err_nx;
  logic [CNT_W-1:0]  stall_nx;
  logic              load_use;
  logic              raw_stall;
  logic              unused_in;

  // A load whose destination is read by the instruction in ID needs one bubble.
  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

`ifdef HAZARD_FWD_EN
  assign raw_stall = 1'b0;
  assign unused_in = ex_regwrite;

  // EX/MEM result has priority over MEM/WB since it is the younger producer.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rs))
      forward_a = 2'b10;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rs))
      forward_a = 2'b01;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == ex_rt))
      forward_b = 2'b10;
    else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == ex_rt))
      forward_b = 2'b01;
  end
`else
  // Without forwarding, wait until producers in EX and MEM have retired; WB writes early enough.
  assign raw_stall =
    (ex_regwrite && (ex_rd != 5'd0) &&
     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)))) ||
    (mem_regwrite && (mem_rd != 5'd0) &&
     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt))));
  assign unused_in = ^{ex_rs, ex_rt, wb_regwrite, wb_rd};
  assign forward_a = 2'b00;
  assign forward_b = 2'b00;
`endif

  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nx;
      wait_cnt     <= wait_cnt_nx;
      mem_err      <= mem_err_nx;
      stall_cycles <= stall_nx;
    end
  end

  // Next state and pipeline controls; priority HALT > mem_wait > branch > jump > hazard.
  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    mem_err_nx   = mem_err;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;

    if (startin) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (state == HALT) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (mem_wait) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
        state_nx   = HALT;
        mem_err_nx = 1'b1;
      end else begin
        state_nx    = FREEZE;
        wait_cnt_nx = wait_cnt + WAIT_W'(1);
      end
    end else begin
      state_nx    = RUN;
      wait_cnt_nx = '0;
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (id_jump) begin
        if_id_flush = 1'b1;
      end else if (load_use || raw_stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    stall_nx = stall_cycles;
    if (!pc_write && (stall_cycles != {CNT_W{1'b1}}))
      stall_nx = stall_cycles + CNT_W'(1);
  end

endmodule
